// File: rtl/divisor_frecuencia_multicanal.sv
// Multi-channel programmable frequency divider.
// Every channel turns the system clock into a 50% square wave whose
// half-period can be rewritten at runtime. It also emits a one-cycle tick
// in the cycle its square wave rises.
module divisor_frecuencia_multicanal #(
  parameter int N_CH       = 4,
  parameter int DIV_W      = 26,
  parameter int RESET_HALF = 5000000,
  localparam int CH_W      = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_half,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick
);

  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] ZERO = '0;

  logic [DIV_W-1:0] r_half [N_CH];
  logic [DIV_W-1:0] r_cnt  [N_CH];
  logic [N_CH-1:0]  r_clk_out;
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  w_wr_hit;

  // Decode which channel a write targets; an index beyond the last channel matches nothing
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        w_wr_hit[i] = 1'b1;
      end
    end
  end

  // Per-channel half-period, phase counter and registered outputs, with priority reset > sync > write > count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_half[i] <= DIV_W'(RESET_HALF);
        r_cnt[i]  <= ZERO;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_wr_hit[i]) begin
          r_half[i] <= wr_half;
        end
        if (sync || w_wr_hit[i] || (r_half[i] == ZERO)) begin
          r_cnt[i]     <= ZERO;
          r_clk_out[i] <= 1'b0;
          r_tick[i]    <= 1'b0;
        end else if (!en[i]) begin
          r_tick[i] <= 1'b0;
        end else if (r_cnt[i] == (r_half[i] - ONE)) begin
          r_cnt[i]     <= ZERO;
          r_clk_out[i] <= ~r_clk_out[i];
          r_tick[i]    <= ~r_clk_out[i];
        end else begin
          r_cnt[i]  <= r_cnt[i] + ONE;
          r_tick[i] <= 1'b0;
        end
      end
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule

// File: tb/tb_divisor_frecuencia_multicanal.sv
// Self-checking bench for the multi-channel divider: directed scenarios with
// literal expectations, then randomized traffic checked each cycle against a
// behavioural model based on enabled-cycle counts.
module tb_divisor_frecuencia_multicanal;

  localparam int N_CH       = 5;
  localparam int DIV_W      = 8;
  localparam int RESET_HALF = 5;
  localparam int CH_W       = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   en;
  logic              sync;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_half;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;

  int vectors     = 0;
  int miscompares = 0;
  bit checkOn     = 1'b0;

  // Model state: programmed half-period, enabled cycles since phase 0 (mod 2*half),
  // and whether the channel advanced on the last edge
  int mHalf [N_CH];
  int mN    [N_CH];
  bit mAdv  [N_CH];

  divisor_frecuencia_multicanal #(
    .N_CH(N_CH), .DIV_W(DIV_W), .RESET_HALF(RESET_HALF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out), .tick(tick)
  );

  // 100 MHz-style bench clock; the absolute period does not matter
  always #5 clk = ~clk;

  function automatic bit expOut(int ch);
    if (mHalf[ch] == 0) return 1'b0;
    return ((mN[ch] / mHalf[ch]) % 2) == 1;
  endfunction

  function automatic bit expTick(int ch);
    return mAdv[ch] && (mHalf[ch] != 0) && (mN[ch] == mHalf[ch]);
  endfunction

  // Advance the behavioural model on every active edge using the same inputs the DUT samples
  always @(posedge clk) begin
    int hitCh;
    hitCh = (wr_en && (int'(wr_ch) < N_CH)) ? int'(wr_ch) : -1;
    for (int i = 0; i < N_CH; i++) mAdv[i] = 1'b0;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        mHalf[i] = RESET_HALF;
        mN[i]    = 0;
      end
    end else begin
      if (hitCh >= 0) mHalf[hitCh] = int'(wr_half);
      for (int i = 0; i < N_CH; i++) begin
        if (sync || (i == hitCh) || (mHalf[i] == 0)) begin
          mN[i] = 0;
        end else if (en[i]) begin
          mN[i]   = (mN[i] + 1) % (2 * mHalf[i]);
          mAdv[i] = 1'b1;
        end
      end
    end
  end

  // Compare every channel against the model on the inactive edge
  always @(negedge clk) begin
    if (checkOn) begin
      for (int i = 0; i < N_CH; i++) begin
        vectors++;
        if (clk_out[i] !== expOut(i)) begin
          miscompares++;
          $display("[TB] FAIL model clk_out[%0d] t=%0t: got %b expected %b", i, $time, clk_out[i], expOut(i));
        end
        vectors++;
        if (tick[i] !== expTick(i)) begin
          miscompares++;
          $display("[TB] FAIL model tick[%0d] t=%0t: got %b expected %b", i, $time, tick[i], expTick(i));
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and return at the next falling edge
  task automatic applyStimulus(input logic rst, input logic [N_CH-1:0] e, input logic s,
                               input logic we, input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] h);
    reset   = rst;
    en      = e;
    sync    = s;
    wr_en   = we;
    wr_ch   = ch;
    wr_half = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic [N_CH-1:0] e);
    applyStimulus(1'b0, e, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic writeCh(input int ch, input int h);
    applyStimulus(1'b0, '1, 1'b0, 1'b1, CH_W'(ch), DIV_W'(h));
  endtask

  // Literal expectation check that pins the model to hand-computed values
  task automatic checkOutput(input string name, input logic [N_CH-1:0] actual, input logic [N_CH-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  initial begin
    reset = 1'b1; en = '1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, '1, 1'b0, 1'b0, '0, '0);
    checkOn = 1'b1;
    checkOutput("reset clk_out", clk_out, '0);
    checkOutput("reset tick", tick, '0);

    // Reset half of 5: every channel rises after 5 enabled cycles, falls after 10
    for (int k = 1; k <= 10; k++) begin
      idle('1);
      checkOutput($sformatf("reset-half clk_out[0] k=%0d", k), N_CH'(clk_out[0]), N_CH'((k >= 5) && (k < 10)));
      checkOutput($sformatf("reset-half tick[0] k=%0d", k), N_CH'(tick[0]), N_CH'(k == 5));
    end

    // Half of 3 on channel 1: 000111 pattern, ticks 3 and 9 cycles after the write
    writeCh(1, 3);
    checkOutput("ch1 after write", N_CH'(clk_out[1]), '0);
    for (int j = 1; j <= 12; j++) begin
      idle('1);
      checkOutput($sformatf("ch1 clk_out j=%0d", j), N_CH'(clk_out[1]), N_CH'((j % 6) >= 3));
      checkOutput($sformatf("ch1 tick j=%0d", j), N_CH'(tick[1]), N_CH'((j % 6) == 3));
    end

    // Half of 1 toggles every cycle, then half of 0 parks the channel low
    writeCh(2, 1);
    for (int j = 1; j <= 6; j++) begin
      idle('1);
      checkOutput($sformatf("ch2 h1 clk_out j=%0d", j), N_CH'(clk_out[2]), N_CH'(j % 2));
      checkOutput($sformatf("ch2 h1 tick j=%0d", j), N_CH'(tick[2]), N_CH'(j % 2));
    end
    writeCh(2, 0);
    for (int j = 1; j <= 5; j++) begin
      idle('1);
      checkOutput("ch2 h0 clk_out", N_CH'(clk_out[2]), '0);
      checkOutput("ch2 h0 tick", N_CH'(tick[2]), '0);
    end

    // Half of 4 on channel 0, frozen at count 2 for 5 cycles, toggles 2 cycles after resuming
    writeCh(0, 4);
    idle('1);
    idle('1);
    for (int j = 0; j < 5; j++) begin
      idle(5'b11110);
      checkOutput("ch0 frozen clk_out", N_CH'(clk_out[0]), '0);
    end
    idle('1);
    checkOutput("ch0 resume+1 clk_out", N_CH'(clk_out[0]), '0);
    idle('1);
    checkOutput("ch0 resume+2 clk_out", N_CH'(clk_out[0]), N_CH'(1));
    checkOutput("ch0 resume+2 tick", N_CH'(tick[0]), N_CH'(1));

    // Halves 3,5,7 then sync with a simultaneous write of half 2 to channel 3
    writeCh(0, 3);
    writeCh(1, 5);
    writeCh(2, 7);
    for (int j = 0; j < 11; j++) idle('1);
    applyStimulus(1'b0, '1, 1'b1, 1'b1, CH_W'(3), DIV_W'(2));
    checkOutput("sync clk_out", clk_out, '0);
    checkOutput("sync tick", tick, '0);
    for (int j = 1; j <= 12; j++) begin
      if (j == 9) applyStimulus(1'b0, '1, 1'b0, 1'b1, CH_W'(5), DIV_W'(9));
      else idle('1);
      checkOutput($sformatf("ch3 h2 clk_out j=%0d", j), N_CH'(clk_out[3]), N_CH'((j % 4) >= 2));
      checkOutput($sformatf("ch3 h2 tick j=%0d", j), N_CH'(tick[3]), N_CH'((j % 4) == 2));
    end

    // Reset mid-run returns everything to the reset half-period
    applyStimulus(1'b1, '1, 1'b0, 1'b0, '0, '0);
    checkOutput("midreset clk_out", clk_out, '0);
    for (int k = 1; k <= 5; k++) idle('1);
    checkOutput("midreset rise clk_out", clk_out, '1);
    checkOutput("midreset rise tick", tick, '1);

    // Maximum half-period on channel 4
    writeCh(4, 255);
    for (int j = 1; j <= 255; j++) begin
      idle('1);
      if (j == 254) checkOutput("max half pre-rise", N_CH'(clk_out[4]), '0);
    end
    checkOutput("max half rise clk_out", N_CH'(clk_out[4]), N_CH'(1));
    checkOutput("max half rise tick", N_CH'(tick[4]), N_CH'(1));

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      logic rst, s, we;
      logic [CH_W-1:0] ch;
      logic [DIV_W-1:0] h;
      rst = ($urandom_range(0, 499) == 0);
      s   = ($urandom_range(0, 49) == 0);
      we  = ($urandom_range(0, 9) == 0);
      ch  = CH_W'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       h = DIV_W'(255);
        1:       h = DIV_W'($urandom_range(0, 40));
        default: h = DIV_W'($urandom_range(0, 6));
      endcase
      applyStimulus(rst, N_CH'($urandom), s, we, ch, h);
    end

    checkOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
